// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding, default timing constants and counter sizing for the PLL reset controller.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 65536;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// pll_reset_ctrl_if: lock/relock inputs and reset/status outputs of the PLL reset controller.
interface pll_reset_ctrl_if;

    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] fail_cnt;
    logic [7:0] lost_cnt;

    modport master (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, state, fail_cnt, lost_cnt
    );

    modport slave (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, state, fail_cnt, lost_cnt
    );

endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer for an asynchronous status bit, resets to 0.
module pll_lock_sync (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences the PLL reset, qualifies lock, and holds the system reset until lock is stable.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input logic             refclk,
    input logic             rst,
    pll_reset_ctrl_if.slave bus
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);

    state_t        st, nxt;
    logic [CW-1:0] cnt;
    logic          locked_s, fail_inc, lost_inc;

    pll_lock_sync u_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (bus.pll_locked),
        .q      (locked_s)
    );

    // relock_req overrides every transition and suppresses both event counters
    always_comb begin
        nxt      = st;
        fail_inc = 1'b0;
        lost_inc = 1'b0;
        if (bus.relock_req) nxt = PLL_RESET;
        else case (st)
            PLL_RESET: if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s) nxt = STABLE;
                else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    nxt      = PLL_RESET;
                    fail_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) nxt = WAIT_LOCK;
                else if (cnt == CW'(LOCK_STABLE - 1)) nxt = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    nxt      = PLL_RESET;
                    lost_inc = 1'b1;
                end
            end
        endcase
    end

    // cnt is frozen in RUN, the only state without a terminal count, so it never wraps
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st           <= PLL_RESET;
            cnt          <= '0;
            bus.pll_rst  <= 1'b1;
            bus.sys_rst  <= 1'b1;
            bus.ready    <= 1'b0;
            bus.fail_cnt <= 8'd0;
            bus.lost_cnt <= 8'd0;
        end else begin
            st           <= nxt;
            cnt          <= (bus.relock_req || nxt != st) ? '0 : (st == RUN ? cnt : cnt + 1'b1);
            bus.pll_rst  <= nxt == PLL_RESET;
            bus.sys_rst  <= nxt != RUN;
            bus.ready    <= nxt == RUN;
            if (fail_inc && bus.fail_cnt != 8'hff) bus.fail_cnt <= bus.fail_cnt + 1'b1;
            if (lost_inc && bus.lost_cnt != 8'hff) bus.lost_cnt <= bus.lost_cnt + 1'b1;
        end
    end

    assign bus.state = st;

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer and lock supervisor for the core's system PLL (50 MHz reference in, 16 MHz / 2 MHz out). It runs on the reference clock and drives the PLL reset. It synchronizes and qualifies the PLL lock flag, and holds the downstream system reset asserted until lock has been stable for a programmable interval. On lock timeout, loss of lock, or a software relock request, it re-sequences the PLL automatically and keeps saturating event counters for status readout.

## Interface
Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high per PLL reset pulse (≥2)
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release (≥2)
- LOCK_TIMEOUT, 65536: refclk cycles allowed in WAIT_LOCK before retry (≥2)

Ports:
- refclk  in  1  reference clock, 50 MHz; sole clock of the block
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock flag; asynchronous to refclk
- relock_req  in  1  single-cycle request to re-sequence the PLL
- pll_rst  out  1  reset to PLL
- sys_rst  out  1  reset to logic clocked by PLL outputs; high = in reset
- ready  out  1  PLL locked and qualified (equals ~sys_rst)
- state  out  2  current FSM state, for status
- fail_cnt  out  8  saturating count of lock timeouts
- lost_cnt  out  8  saturating count of lock losses while in RUN

## Operation
- `pll_locked` passes through a 2-flop synchronizer. The result is `locked_s`, and only `locked_s` is used by the FSM.
- One shared cycle counter `cnt`. It is cleared on every state change and counts otherwise.
- States: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- PLL_RESET: `pll_rst`=1, `sys_rst`=1.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - If locked_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, increment fail_cnt and go to PLL_RESET.
  - Lock has priority over timeout on the same edge.
- STABLE: `sys_rst`=1.
  - If locked_s=0, return to WAIT_LOCK; this is not counted as a loss.
  - Else if cnt==LOCK_STABLE-1, go to RUN.
- RUN: `sys_rst`=0, `ready`=1.
  - If locked_s=0, increment lost_cnt and go to PLL_RESET.
- relock_req=1 in any state forces PLL_RESET with cnt cleared.
  - If already in PLL_RESET, the pulse restarts.
  - relock_req has priority over timeout and lock loss on the same edge; neither counter increments.
- fail_cnt and lost_cnt saturate at 255. They are cleared only by `rst`.
- Counter width is $clog2 of the largest parameter. The counter never wraps, because every state exits at or before its terminal value.

## Timing
- While `rst`=1, and immediately after it asserts:
  - state=PLL_RESET, cnt=0, pll_rst=1, sys_rst=1, ready=0
  - fail_cnt=0, lost_cnt=0
  - both synchronizer flops = 0
- The `rst` deassertion is not synchronized here. The top level supplies a reset that is already release-synchronized to refclk.
- All outputs are registered and change on the same edge as `state`. There is no combinational path from any input to any output.
- After `rst` release, pll_rst stays high for exactly RST_CYCLES more edges.
- Lock latency: if the first edge sampling pll_locked=1 in WAIT_LOCK is edge k, then:
  - STABLE is entered at edge k+2;
  - with lock steady, RUN (ready=1, sys_rst=0) is entered at edge k+2+LOCK_STABLE.
- Lock loss in RUN: the first edge sampling pll_locked=0 is edge k. At edge k+2, sys_rst=1 and pll_rst=1.
- relock_req sampled at edge k: PLL_RESET is entered at edge k.
- Reset mid-operation: asynchronous return to the reset values above. Any in-progress count is discarded.

## Structure
- Package `pll_ctrl_pkg`: state enum (2-bit encoding above), default parameter constants, counter-width function.
- Sub-module `pll_lock_sync`: a 2-flop synchronizer on refclk/rst with reset value 0. It is reused for other async status bits.
- The FSM, counter, and status counters stay in `pll_reset_ctrl`.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
- Nominal bring-up:
  - Stimulus: release rst; raise pll_locked 10 cycles later.
  - Response: pll_rst high for 4 cycles after release; ready=1 exactly 10 edges after the first edge sampling the lock; fail_cnt=0.
- Timeout retry:
  - Stimulus: hold pll_locked=0.
  - Response: a PLL_RESET pulse every 36 cycles; fail_cnt increments per retry and holds at 255 after 255 retries.
- Lock glitch in STABLE:
  - Stimulus: drop pll_locked for 1 cycle at STABLE cnt=5.
  - Response: return to WAIT_LOCK, then a full 8-cycle requalification; lost_cnt unchanged; sys_rst never deasserts.
- Loss in RUN:
  - Stimulus: drop pll_locked while ready=1.
  - Response: sys_rst=1 and pll_rst=1 two edges later; lost_cnt goes 0→1; after lock returns, normal requalification.
- Simultaneous events:
  - Stimulus: relock_req coincident with the lock drop in RUN, and separately coincident with the WAIT_LOCK timeout edge.
  - Response: PLL_RESET on that edge; lost_cnt and fail_cnt unchanged.
- Async reset mid-STABLE:
  - Stimulus: assert rst between clock edges at cnt=3.
  - Response: outputs take their reset values immediately, with no clock edge; the bring-up sequence restarts cleanly after release.
